// File: rtl/wvl_energy_cal_stage_if.sv
// Photon stream bundle for the energy calibration stage.
// The master drives photons in; the slave returns calibrated photons.
interface wvl_energy_cal_stage_if #(
  parameter int CHAN_W  = 8,
  parameter int PHASE_W = 16,
  parameter int TS_W    = 24
);
  logic                      in_valid;
  logic [CHAN_W-1:0]         in_chan;
  logic signed [PHASE_W-1:0] in_phase;
  logic [TS_W-1:0]           in_ts;

  logic                      out_valid;
  logic [CHAN_W-1:0]         out_chan;
  logic signed [PHASE_W-1:0] out_energy;
  logic [TS_W-1:0]           out_ts;
  logic                      out_cal;
  logic                      out_sat;

  modport master (
    output in_valid, in_chan, in_phase, in_ts,
    input  out_valid, out_chan, out_energy, out_ts, out_cal, out_sat
  );

  modport slave (
    input  in_valid, in_chan, in_phase, in_ts,
    output out_valid, out_chan, out_energy, out_ts, out_cal, out_sat
  );
endinterface

// File: rtl/wvl_energy_cal_stage.sv
// Per-photon phase-to-energy calibration: energy = round(phase * gain) + offset, clamped.
// Fixed 4-cycle latency, one photon per cycle; photon and saturation counters for readback.
module wvl_energy_cal_stage #(
  parameter int CHAN_W    = 8,
  parameter int PHASE_W   = 16,
  parameter int GAIN_W    = 16,
  parameter int GAIN_FRAC = 14,
  parameter int TS_W      = 24
) (
  input  logic                      user_clk,
  input  logic                      user_rst,
  input  logic [31:0]               ctrl_word,
  input  logic                      coef_we,
  input  logic [CHAN_W-1:0]         coef_addr,
  input  logic [GAIN_W+PHASE_W-1:0] coef_data,
  output logic [31:0]               photon_cnt,
  output logic [31:0]               sat_cnt,
  wvl_energy_cal_stage_if.slave     pho
);
  localparam int COEF_W = GAIN_W + PHASE_W;
  localparam int DEPTH  = 2**CHAN_W;
  localparam int PROD_W = PHASE_W + GAIN_W + 1;
  localparam int SUM_W  = PROD_W + 2;

  localparam logic [GAIN_W-1:0]       GAIN_ONE     = GAIN_W'(2**GAIN_FRAC);
  localparam logic [COEF_W-1:0]       COEF_DEFAULT = {GAIN_ONE, {PHASE_W{1'b0}}};
  localparam logic signed [SUM_W-1:0] ROUND_HALF   = SUM_W'(2**(GAIN_FRAC-1));
  localparam logic signed [SUM_W-1:0] E_MAX        = SUM_W'(2**(PHASE_W-1) - 1);
  localparam logic signed [SUM_W-1:0] E_MIN        = ~E_MAX;

  logic [1:0] ctrl_q;
  logic       ctrl_unused;
  assign ctrl_unused = ^ctrl_word[31:2];

  // Table powers up at unity gain / zero offset and is deliberately outside reset.
  logic [COEF_W-1:0] coef_mem [DEPTH] = '{default: COEF_DEFAULT};
  logic [COEF_W-1:0] rd_coef;

  logic                      s0_valid, s1_valid, s2_valid, s3_valid;
  logic                      s0_mode, s1_mode, s2_mode, s3_mode;
  logic [CHAN_W-1:0]         s0_chan, s1_chan, s2_chan, s3_chan;
  logic signed [PHASE_W-1:0] s0_phase, s1_phase, s2_phase, s3_phase;
  logic [TS_W-1:0]           s0_ts, s1_ts, s2_ts, s3_ts;
  logic [GAIN_W-1:0]         s1_gain;
  logic signed [PHASE_W-1:0] s1_offset, s2_offset;
  logic signed [PROD_W-1:0]  s2_prod;
  logic signed [SUM_W-1:0]   s3_sum;

  logic                      sat_hi, sat_lo, res_sat;
  logic signed [PHASE_W-1:0] cal_energy;

  // Read-first: a same-cycle write to the read address lands after the read.
  always_ff @(posedge user_clk) begin
    if (coef_we) coef_mem[coef_addr] <= coef_data;
    rd_coef <= coef_mem[pho.in_chan];
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      ctrl_q   <= '0;
      s0_valid <= 1'b0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_word[1:0];
      s0_valid <= pho.in_valid;
      s1_valid <= s0_valid;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
    end
  end

  // The mode bit is captured with the photon so later mode changes cannot affect it.
  always_ff @(posedge user_clk) begin
    s0_mode   <= ctrl_q[0];
    s0_chan   <= pho.in_chan;
    s0_phase  <= pho.in_phase;
    s0_ts     <= pho.in_ts;

    s1_mode   <= s0_mode;
    s1_chan   <= s0_chan;
    s1_phase  <= s0_phase;
    s1_ts     <= s0_ts;
    s1_gain   <= rd_coef[COEF_W-1:PHASE_W];
    s1_offset <= rd_coef[PHASE_W-1:0];

    s2_mode   <= s1_mode;
    s2_chan   <= s1_chan;
    s2_phase  <= s1_phase;
    s2_ts     <= s1_ts;
    s2_offset <= s1_offset;
    s2_prod   <= PROD_W'(s1_phase) * PROD_W'($signed({1'b0, s1_gain}));

    s3_mode   <= s2_mode;
    s3_chan   <= s2_chan;
    s3_phase  <= s2_phase;
    s3_ts     <= s2_ts;
    s3_sum    <= ((SUM_W'(s2_prod) + ROUND_HALF) >>> GAIN_FRAC) + SUM_W'(s2_offset);
  end

  always_comb begin
    sat_hi     = (s3_sum > E_MAX);
    sat_lo     = (s3_sum < E_MIN);
    cal_energy = s3_sum[PHASE_W-1:0];
    if (sat_hi)      cal_energy = E_MAX[PHASE_W-1:0];
    else if (sat_lo) cal_energy = E_MIN[PHASE_W-1:0];
  end

  assign res_sat = s3_mode & (sat_hi | sat_lo);

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      pho.out_valid  <= 1'b0;
      pho.out_chan   <= '0;
      pho.out_energy <= '0;
      pho.out_ts     <= '0;
      pho.out_cal    <= 1'b0;
      pho.out_sat    <= 1'b0;
    end else begin
      pho.out_valid  <= s3_valid;
      pho.out_chan   <= s3_chan;
      pho.out_energy <= s3_mode ? cal_energy : s3_phase;
      pho.out_ts     <= s3_ts;
      pho.out_cal    <= s3_mode;
      pho.out_sat    <= res_sat;
    end
  end

  // Counters track the output register, so they step on the same edge as out_valid.
  always_ff @(posedge user_clk) begin
    if (user_rst || ctrl_q[1]) begin
      photon_cnt <= '0;
      sat_cnt    <= '0;
    end else begin
      if (s3_valid && photon_cnt != '1) photon_cnt <= photon_cnt + 32'd1;
      if (s3_valid && res_sat && sat_cnt != '1) sat_cnt <= sat_cnt + 32'd1;
    end
  end
endmodule

// File: tb/tb_wvl_energy_cal_stage.sv
// Self-checking bench for wvl_energy_cal_stage: directed scenarios plus randomized
// traffic compared against an arithmetic reference model with a 4-cycle delay line.
module tb_wvl_energy_cal_stage;
  localparam int CHAN_W    = 8;
  localparam int PHASE_W   = 16;
  localparam int GAIN_W    = 16;
  localparam int GAIN_FRAC = 14;
  localparam int TS_W      = 24;
  localparam longint ONE   = longint'(1) << GAIN_FRAC;
  localparam longint EMAX  = (longint'(1) << (PHASE_W-1)) - 1;
  localparam longint EMIN  = -(longint'(1) << (PHASE_W-1));

  logic        user_clk = 1'b0;
  logic        user_rst;
  logic [31:0] ctrl_word;
  logic        coef_we;
  logic [CHAN_W-1:0] coef_addr;
  logic [GAIN_W+PHASE_W-1:0] coef_data;
  logic [31:0] photon_cnt;
  logic [31:0] sat_cnt;

  wvl_energy_cal_stage_if #(.CHAN_W(CHAN_W), .PHASE_W(PHASE_W), .TS_W(TS_W)) pho ();

  wvl_energy_cal_stage #(
    .CHAN_W(CHAN_W), .PHASE_W(PHASE_W), .GAIN_W(GAIN_W), .GAIN_FRAC(GAIN_FRAC), .TS_W(TS_W)
  ) dut (
    .user_clk  (user_clk),
    .user_rst  (user_rst),
    .ctrl_word (ctrl_word),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .photon_cnt(photon_cnt),
    .sat_cnt   (sat_cnt),
    .pho       (pho)
  );

  always #5 user_clk = ~user_clk;

  typedef struct {
    bit v;
    int energy;
    bit cal;
    bit sat;
    int chan;
    int ts;
  } exp_t;

  exp_t        ring [8];
  exp_t        cur;
  int          m_gain [256];
  int          m_off  [256];
  bit [1:0]    m_ctrl;
  int unsigned m_pcnt, m_scnt;
  int          cyc;
  int          vectors;
  int          fails;

  // Energy from the calibration rule: floor((phase*gain + half) / 2^frac) + offset, clamped.
  function automatic exp_t model_photon(bit mode, int chan, int phase, int ts);
    exp_t e;
    longint num, r, s;
    e.v = 1; e.chan = chan; e.ts = ts; e.cal = mode; e.sat = 0; e.energy = phase;
    if (mode) begin
      num = longint'(phase) * longint'(m_gain[chan]) + ONE / 2;
      r = num / ONE;
      if (num < 0 && r * ONE != num) r = r - 1;
      s = r + longint'(m_off[chan]);
      if (s > EMAX) begin s = EMAX; e.sat = 1; end
      else if (s < EMIN) begin s = EMIN; e.sat = 1; end
      e.energy = int'(s);
    end
    return e;
  endfunction

  // Advance one clock and update the model; leaves the bench 1 time unit after the edge.
  task automatic tick();
    exp_t em;
    @(posedge user_clk);
    cyc++;
    if (user_rst) begin
      for (int i = 0; i < 8; i++) ring[i].v = 0;
      cur.v  = 0;
      m_pcnt = 0;
      m_scnt = 0;
      m_ctrl = 2'b00;
    end else begin
      em = ring[cyc % 8];
      cur = em;
      if (m_ctrl[1]) begin
        m_pcnt = 0;
        m_scnt = 0;
      end else if (em.v) begin
        if (m_pcnt != 32'hFFFF_FFFF) m_pcnt++;
        if (em.sat && m_scnt != 32'hFFFF_FFFF) m_scnt++;
      end
      if (pho.in_valid)
        ring[(cyc + 4) % 8] = model_photon(m_ctrl[0], int'(pho.in_chan),
                                           int'(pho.in_phase), int'(pho.in_ts));
      else
        ring[(cyc + 4) % 8].v = 0;
      m_ctrl = ctrl_word[1:0];
    end
    if (coef_we) begin
      m_gain[coef_addr] = int'(coef_data[31:16]);
      m_off[coef_addr]  = int'($signed(coef_data[15:0]));
    end
    #1;
  endtask

  task automatic put_photon(bit v, int chan, int phase, int ts);
    pho.in_valid = v;
    pho.in_chan  = CHAN_W'(chan);
    pho.in_phase = PHASE_W'(phase);
    pho.in_ts    = TS_W'(ts);
  endtask

  task automatic put_coef(bit we, int addr, int gain, int off);
    coef_we   = we;
    coef_addr = CHAN_W'(addr);
    coef_data = {GAIN_W'(gain), PHASE_W'(off)};
  endtask

  task automatic test_reset();
    user_rst = 1'b1;
    put_photon(1, 3, 99, 5);
    tick();
    tick();
    vectors++;
    if (pho.out_valid !== 1'b0 || photon_cnt !== 32'd0 || sat_cnt !== 32'd0) begin
      fails++;
      $display("FAIL reset_state: got v=%0b pc=%0d sc=%0d want v=0 pc=0 sc=0",
               pho.out_valid, photon_cnt, sat_cnt);
    end
    user_rst = 1'b0;
    put_photon(0, 0, 0, 0);
  endtask

  task automatic test_bypass();
    ctrl_word = 32'd0;
    put_photon(1, 5, -1234, 'h00ABCD);
    tick();
    put_photon(0, 0, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      vectors++;
      if (pho.out_valid !== cur.v || pho.out_valid !== (k == 4)) begin
        fails++;
        $display("FAIL bypass_valid k=%0d: got %0b want %0b", k, pho.out_valid, (k == 4));
      end
      if (k == 4) begin
        vectors++;
        if ($signed(pho.out_energy) !== -1234 || pho.out_cal !== 1'b0 || pho.out_sat !== 1'b0 ||
            pho.out_ts !== 24'h00ABCD || pho.out_chan !== 8'd5 || photon_cnt !== 32'd1) begin
          fails++;
          $display("FAIL bypass_data: got e=%0d cal=%0b sat=%0b ts=%h ch=%0d pc=%0d want e=-1234 cal=0 sat=0 ts=00abcd ch=5 pc=1",
                   $signed(pho.out_energy), pho.out_cal, pho.out_sat, pho.out_ts, pho.out_chan, photon_cnt);
        end
      end
    end
  endtask

  task automatic test_calibrate();
    put_coef(1, 5, 'h8000, 100);
    ctrl_word = 32'd1;
    tick();
    put_coef(0, 0, 0, 0);
    put_photon(1, 5, -1234, 77);
    tick();
    put_photon(0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      vectors++;
      if (pho.out_valid !== cur.v) begin
        fails++;
        $display("FAIL calibrate_valid k=%0d: got %0b want %0b", k, pho.out_valid, cur.v);
      end
    end
    vectors++;
    if ($signed(pho.out_energy) !== -2368 || pho.out_cal !== 1'b1 || pho.out_sat !== 1'b0 ||
        pho.out_ts !== 24'd77) begin
      fails++;
      $display("FAIL calibrate_data: got e=%0d cal=%0b sat=%0b ts=%0d want e=-2368 cal=1 sat=0 ts=77",
               $signed(pho.out_energy), pho.out_cal, pho.out_sat, pho.out_ts);
    end
  endtask

  task automatic test_saturation();
    put_coef(1, 9, 'hFFFF, 0);
    tick();
    put_coef(0, 0, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      if (k == 1)      put_photon(1, 9, 20000, 1);
      else if (k == 2) put_photon(1, 9, -20000, 2);
      else             put_photon(0, 0, 0, 0);
      tick();
      vectors++;
      if (pho.out_valid !== cur.v) begin
        fails++;
        $display("FAIL sat_valid k=%0d: got %0b want %0b", k, pho.out_valid, cur.v);
      end
      if (k == 5 || k == 6) begin
        vectors++;
        if ($signed(pho.out_energy) !== ((k == 5) ? 32767 : -32768) || pho.out_sat !== 1'b1 ||
            pho.out_cal !== 1'b1) begin
          fails++;
          $display("FAIL sat_data k=%0d: got e=%0d sat=%0b cal=%0b want e=%0d sat=1 cal=1",
                   k, $signed(pho.out_energy), pho.out_sat, pho.out_cal, (k == 5) ? 32767 : -32768);
        end
      end
    end
    vectors++;
    if (sat_cnt !== 32'd2 || sat_cnt !== m_scnt || photon_cnt !== m_pcnt) begin
      fails++;
      $display("FAIL sat_count: got sc=%0d pc=%0d want sc=2 pc=%0d", sat_cnt, photon_cnt, m_pcnt);
    end
    ctrl_word = 32'd3;
    tick();
    ctrl_word = 32'd1;
    tick();
    vectors++;
    if (photon_cnt !== 32'd0 || sat_cnt !== 32'd0) begin
      fails++;
      $display("FAIL count_clear: got pc=%0d sc=%0d want pc=0 sc=0", photon_cnt, sat_cnt);
    end
  endtask

  task automatic test_mode_toggle();
    int want [8];
    int gv [8];
    int gc [8];
    int ng;
    want = '{10, 10, 10, 10, 120, 120, 120, 120};
    ng = 0;
    ctrl_word = 32'd0;
    tick();
    for (int i = 1; i <= 12; i++) begin
      if (i <= 8) begin
        put_photon(1, 5, 10, i);
        ctrl_word = (i >= 4) ? 32'd1 : 32'd0;
      end else begin
        put_photon(0, 0, 0, 0);
      end
      tick();
      vectors++;
      if (pho.out_valid !== cur.v) begin
        fails++;
        $display("FAIL toggle_valid i=%0d: got %0b want %0b", i, pho.out_valid, cur.v);
      end
      if (pho.out_valid === 1'b1 && ng < 8) begin
        gv[ng] = int'($signed(pho.out_energy));
        gc[ng] = cyc;
        ng++;
      end
    end
    vectors++;
    if (ng !== 8) begin
      fails++;
      $display("FAIL toggle_count: got %0d outputs want 8", ng);
    end
    for (int j = 0; j < ng; j++) begin
      vectors++;
      if (gv[j] !== want[j] || gc[j] !== gc[0] + j) begin
        fails++;
        $display("FAIL toggle_seq j=%0d: got e=%0d at offset %0d want e=%0d at offset %0d",
                 j, gv[j], gc[j] - gc[0], want[j], j);
      end
    end
  endtask

  task automatic test_collision();
    int got [2];
    int ng;
    ng = 0;
    ctrl_word = 32'd1;
    put_coef(1, 7, 'h8000, 0);
    put_photon(1, 7, 50, 1);
    tick();
    put_coef(0, 0, 0, 0);
    put_photon(1, 7, 50, 2);
    tick();
    put_photon(0, 0, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      vectors++;
      if (pho.out_valid !== cur.v) begin
        fails++;
        $display("FAIL collide_valid k=%0d: got %0b want %0b", k, pho.out_valid, cur.v);
      end
      if (pho.out_valid === 1'b1 && ng < 2) begin
        got[ng] = int'($signed(pho.out_energy));
        ng++;
      end
    end
    vectors++;
    if (ng !== 2 || got[0] !== 50 || got[1] !== 100) begin
      fails++;
      $display("FAIL collide_data: got n=%0d e0=%0d e1=%0d want n=2 e0=50 e1=100", ng, got[0], got[1]);
    end
  endtask

  task automatic test_reset_midstream();
    int seen;
    seen = 0;
    ctrl_word = 32'd1;
    for (int i = 1; i <= 3; i++) begin
      put_photon(1, 5, 100 * i, i);
      tick();
    end
    user_rst = 1'b1;
    put_photon(1, 5, 77, 9);
    tick();
    vectors++;
    if (pho.out_valid !== 1'b0 || photon_cnt !== 32'd0 || sat_cnt !== 32'd0) begin
      fails++;
      $display("FAIL midrst_state: got v=%0b pc=%0d sc=%0d want v=0 pc=0 sc=0",
               pho.out_valid, photon_cnt, sat_cnt);
    end
    user_rst = 1'b0;
    put_photon(0, 0, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (pho.out_valid !== 1'b0) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      fails++;
      $display("FAIL midrst_flush: got %0d stale outputs want 0", seen);
    end
    put_photon(1, 5, -1234, 3);
    tick();
    put_photon(0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) tick();
    vectors++;
    if (pho.out_valid !== 1'b1 || $signed(pho.out_energy) !== -2368 || pho.out_cal !== 1'b1 ||
        photon_cnt !== 32'd1) begin
      fails++;
      $display("FAIL midrst_table: got v=%0b e=%0d cal=%0b pc=%0d want v=1 e=-2368 cal=1 pc=1",
               pho.out_valid, $signed(pho.out_energy), pho.out_cal, photon_cnt);
    end
  endtask

  task automatic test_random();
    bit          mode;
    bit          clr;
    logic [31:0] rnd;
    int          g, o, ph;
    mode = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (i < 594) begin
        if ($urandom_range(0, 7) == 0) mode = ~mode;
        clr = ($urandom_range(0, 40) == 0);
        rnd = $urandom();
        ctrl_word = {rnd[31:2], clr, mode};
        user_rst = ($urandom_range(0, 150) == 0);
        case ($urandom_range(0, 3))
          0: g = 'hFFFF;
          1: g = 'h4000;
          2: g = $urandom_range(0, 'h3FF);
          default: g = $urandom_range(0, 'hFFFF);
        endcase
        o = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 200) - 100 : $urandom_range(0, 'hFFFF);
        put_coef($urandom_range(0, 3) == 0, $urandom_range(0, 15), g, o);
        case ($urandom_range(0, 5))
          0: ph = 32767;
          1: ph = -32768;
          default: ph = $urandom_range(0, 'hFFFF);
        endcase
        put_photon($urandom_range(0, 3) != 0, $urandom_range(0, 15), ph, $urandom_range(0, 'hFFFFFF));
      end else begin
        user_rst = 1'b0;
        put_coef(0, 0, 0, 0);
        put_photon(0, 0, 0, 0);
      end
      tick();
      vectors++;
      if (pho.out_valid !== cur.v || photon_cnt !== m_pcnt || sat_cnt !== m_scnt) begin
        fails++;
        $display("FAIL random_ctl cyc=%0d: got v=%0b pc=%0d sc=%0d want v=%0b pc=%0d sc=%0d",
                 cyc, pho.out_valid, photon_cnt, sat_cnt, cur.v, m_pcnt, m_scnt);
      end
      if (cur.v) begin
        vectors++;
        if ($signed(pho.out_energy) !== cur.energy || pho.out_cal !== cur.cal ||
            pho.out_sat !== cur.sat || pho.out_chan !== cur.chan || pho.out_ts !== cur.ts) begin
          fails++;
          $display("FAIL random_data cyc=%0d: got e=%0d cal=%0b sat=%0b ch=%0d ts=%0d want e=%0d cal=%0b sat=%0b ch=%0d ts=%0d",
                   cyc, $signed(pho.out_energy), pho.out_cal, pho.out_sat, pho.out_chan, pho.out_ts,
                   cur.energy, cur.cal, cur.sat, cur.chan, cur.ts);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      m_gain[i] = int'(ONE);
      m_off[i]  = 0;
    end
    vectors   = 0;
    fails     = 0;
    cyc       = 0;
    m_ctrl    = 2'b00;
    m_pcnt    = 0;
    m_scnt    = 0;
    cur.v     = 0;
    user_rst  = 1'b1;
    ctrl_word = 32'd0;
    put_coef(0, 0, 0, 0);
    put_photon(0, 0, 0, 0);

    test_reset();
    test_bypass();
    test_calibrate();
    test_saturation();
    test_mode_toggle();
    test_collision();
    test_reset_midstream();
    test_random();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
